avalon_bus_arbiter: RTL and testbench

Two-port arbiter sharing the CPU's single Avalon memory-mapped master port between an instruction-fetch requester and a load/store data requester. It sits between those two requesters and the external bus, grants one transfer at a time, and locks the grant across `waitrequest` stalls. A watchdog flags transfers the slave stalls indefinitely.

---
 rtl/bus_arb_pkg.sv | 34 +++
 rtl/arb_timeout_counter.sv | 55 +++++
 rtl/avalon_bus_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_avalon_bus_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the Avalon two-requester bus arbiter.
// Owner encoding, the data returned on a watchdog abort, the full-word lane
// mask used by instruction fetches, and the contention resolver.
package bus_arb_pkg;

   typedef enum logic [1:0] {
      NONE  = 2'b00,
      INSTR = 2'b01,
      DATA  = 2'b10
   } owner_t;

   localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;
   localparam logic [3:0]  BE_WORD      = 4'b1111;
   localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;
   localparam logic [3:0]  ZERO_BE      = 4'b0000;

   // Pick the requester that drives an idle bus; favour_data breaks ties.
   function automatic owner_t pick_winner(input logic req_i,
                                          input logic req_d,
                                          input logic favour_data);
      owner_t win;
      if (req_i && req_d) begin
         win = favour_data ? DATA : INSTR;
      end else if (req_d) begin
         win = DATA;
      end else if (req_i) begin
         win = INSTR;
      end else begin
         win = NONE;
      end
      return win;
   endfunction

endpackage

// File: rtl/arb_timeout_counter.sv
// Watchdog counting consecutive stalled bus cycles of one transfer.
// expire is a combinational pulse in the stall cycle that brings the count
// up to TIMEOUT_CYCLES, so the arbiter can abort in that same cycle. Any
// non-stalled cycle (completion or idle) restarts the count from zero.
module arb_timeout_counter #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic clk,
   input  logic clear,
   input  logic stall,
   input  logic enable,
   output logic expire
);

   // A zero timeout still needs a legal one-bit counter; enable keeps it idle.
   localparam int CNT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam int LAST_I = (TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0;
   localparam logic [CNT_W-1:0] LAST_CNT = LAST_I[CNT_W-1:0];
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             expire_s;

   // Detect the final stall cycle and compute the next count.
   always_comb begin
      expire_s = 1'b0;
      cnt_d    = cnt_q;
      if (clear) begin
         cnt_d = CNT_ZERO;
      end else if (enable && stall) begin
         if (cnt_q == LAST_CNT) begin
            expire_s = 1'b1;
            cnt_d    = CNT_ZERO;
         end else begin
            cnt_d = cnt_q + CNT_ONE;
         end
      end else begin
         cnt_d = CNT_ZERO;
      end
   end

   // Stall-count register; clear doubles as the synchronous reset.
   always_ff @(posedge clk) begin
      if (clear) begin
         cnt_q <= CNT_ZERO;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire = expire_s;

endmodule

// File: rtl/avalon_bus_arbiter.sv
// Shares one Avalon-MM master port between instruction fetch and load/store.
// On an idle bus the winner drives the bus combinationally (zero added
// latency); a stalled transfer locks ownership until it completes or the
// watchdog aborts it. Optional build macro: ARB_ROUND_ROBIN_EN selects a
// last-served round-robin tie-break; otherwise DATA wins every contention.
module avalon_bus_arbiter #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] i_address,
   input  logic        i_read,
   output logic        i_waitrequest,
   output logic [31:0] i_readdata,
   input  logic [31:0] d_address,
   input  logic        d_read,
   input  logic        d_write,
   input  logic [31:0] d_writedata,
   input  logic [3:0]  d_byteenable,
   output logic        d_waitrequest,
   output logic [31:0] d_readdata,
   output logic [31:0] address,
   output logic        read,
   output logic        write,
   output logic [31:0] writedata,
   output logic [3:0]  byteenable,
   input  logic        waitrequest,
   input  logic [31:0] readdata,
   output logic        bus_error
);

   import bus_arb_pkg::*;

   localparam logic WD_EN = (TIMEOUT_CYCLES != 0);

   owner_t      owner_q;
   owner_t      owner_d;
   owner_t      sel_s;
   logic        req_i_s;
   logic        req_d_s;
   logic        favour_data_s;
   logic        active_s;
   logic        stall_s;
   logic        done_s;
   logic        expire_s;
   logic        bus_error_q;
   logic        bus_error_d;
   logic [31:0] readdata_s;

`ifdef ARB_ROUND_ROBIN_EN
   // 1 = DATA was served last, so INSTR wins the next contention.
   logic        last_data_q;
   logic        last_data_d;
`endif

   // Choose who owns the bus this cycle: the locked owner, else a fresh pick.
   always_comb begin
      req_i_s = i_read;
      req_d_s = d_read | d_write;
`ifdef ARB_ROUND_ROBIN_EN
      favour_data_s = ~last_data_q;
`else
      favour_data_s = 1'b1;
`endif
      case (owner_q)
         NONE:    sel_s = pick_winner(req_i_s, req_d_s, favour_data_s);
         INSTR:   sel_s = INSTR;
         DATA:    sel_s = DATA;
         default: sel_s = NONE;
      endcase
      active_s = (sel_s != NONE) && !reset;
      stall_s  = active_s && waitrequest;
      done_s   = active_s && (!waitrequest || expire_s);
   end

   arb_timeout_counter #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk    (clk),
      .clear  (reset),
      .stall  (stall_s),
      .enable (WD_EN),
      .expire (expire_s)
   );

   // Drive the bus from the selected requester; idle, reset and abort zero it.
   always_comb begin
      address    = ZERO_WORD;
      read       = 1'b0;
      write      = 1'b0;
      writedata  = ZERO_WORD;
      byteenable = ZERO_BE;
      if (active_s && !expire_s) begin
         case (sel_s)
            INSTR: begin
               address    = i_address;
               read       = i_read;
               byteenable = BE_WORD;
            end
            DATA: begin
               address    = d_address;
               read       = d_read;
               write      = d_write;
               writedata  = d_writedata;
               byteenable = d_byteenable;
            end
            default: begin
               address    = ZERO_WORD;
               byteenable = ZERO_BE;
            end
         endcase
      end else begin
         read  = 1'b0;
         write = 1'b0;
      end
   end

   // Requester handshake: only the granted side sees the bus stall.
   always_comb begin
      i_waitrequest = 1'b1;
      d_waitrequest = 1'b1;
      readdata_s    = expire_s ? TIMEOUT_DATA : readdata;
      if (active_s) begin
         case (sel_s)
            INSTR:   i_waitrequest = waitrequest && !expire_s;
            DATA:    d_waitrequest = waitrequest && !expire_s;
            default: begin
               i_waitrequest = 1'b1;
               d_waitrequest = 1'b1;
            end
         endcase
      end else begin
         i_waitrequest = 1'b1;
         d_waitrequest = 1'b1;
      end
   end

   assign i_readdata = readdata_s;
   assign d_readdata = readdata_s;

   // Next owner, sticky error and tie-break pointer.
   always_comb begin
      owner_d     = owner_q;
      bus_error_d = bus_error_q | expire_s;
      if (done_s) begin
         owner_d = NONE;
      end else if (active_s) begin
         owner_d = sel_s;
      end else begin
         owner_d = NONE;
      end
`ifdef ARB_ROUND_ROBIN_EN
      last_data_d = last_data_q;
      if (done_s) begin
         last_data_d = (sel_s == DATA);
      end else begin
         last_data_d = last_data_q;
      end
`endif
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         owner_q     <= NONE;
         bus_error_q <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
         last_data_q <= 1'b1;
`endif
      end else begin
         owner_q     <= owner_d;
         bus_error_q <= bus_error_d;
`ifdef ARB_ROUND_ROBIN_EN
         last_data_q <= last_data_d;
`endif
      end
   end

   assign bus_error = bus_error_q;

endmodule

// File: tb/tb_avalon_bus_arbiter.sv
// Self-checking bench for avalon_bus_arbiter (TIMEOUT_CYCLES = 4).
// Single-cycle vectors from a table, then hand-written multi-cycle sequences.
// Expected contention order follows the ARB_ROUND_ROBIN_EN build option.
module tb_avalon_bus_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
   localparam bit RR_BUILD = 1'b1;
`else
   localparam bit RR_BUILD = 1'b0;
`endif

   logic        clk;
   logic        reset;
   logic [31:0] i_address;
   logic        i_read;
   logic        i_waitrequest;
   logic [31:0] i_readdata;
   logic [31:0] d_address;
   logic        d_read;
   logic        d_write;
   logic [31:0] d_writedata;
   logic [3:0]  d_byteenable;
   logic        d_waitrequest;
   logic [31:0] d_readdata;
   logic [31:0] address;
   logic        read;
   logic        write;
   logic [31:0] writedata;
   logic [3:0]  byteenable;
   logic        waitrequest;
   logic [31:0] readdata;
   logic        bus_error;

   int n_total;
   int n_pass;

   avalon_bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
      .clk           (clk),
      .reset         (reset),
      .i_address     (i_address),
      .i_read        (i_read),
      .i_waitrequest (i_waitrequest),
      .i_readdata    (i_readdata),
      .d_address     (d_address),
      .d_read        (d_read),
      .d_write       (d_write),
      .d_writedata   (d_writedata),
      .d_byteenable  (d_byteenable),
      .d_waitrequest (d_waitrequest),
      .d_readdata    (d_readdata),
      .address       (address),
      .read          (read),
      .write         (write),
      .writedata     (writedata),
      .byteenable    (byteenable),
      .waitrequest   (waitrequest),
      .readdata      (readdata),
      .bus_error     (bus_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] ia;
      logic        ir;
      logic [31:0] da;
      logic        dr;
      logic        dw;
      logic [31:0] dwd;
      logic [3:0]  dbe;
      logic [31:0] rd;
      logic [31:0] e_addr;
      logic        e_rd;
      logic        e_wr;
      logic [31:0] e_wd;
      logic [3:0]  e_be;
      logic        e_iw;
      logic        e_dw;
   } vec_t;

   vec_t vecs [0:5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Advance to 2 time units after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic clear_inputs();
      i_address    = 32'h0;
      i_read       = 1'b0;
      d_address    = 32'h0;
      d_read       = 1'b0;
      d_write      = 1'b0;
      d_writedata  = 32'h0;
      d_byteenable = 4'h0;
      waitrequest  = 1'b0;
      readdata     = 32'h0;
   endtask

   task automatic apply_reset();
      clear_inputs();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   initial begin
      n_total = 0;
      n_pass  = 0;

      // Single-cycle transfers from an idle bus, all completing immediately.
      vecs[0] = '{32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h1111_1111,
                  32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 1'b1, 1'b1};
      vecs[1] = '{32'hAAAA_5555, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h8765_4321, 4'hF, 32'h2222_2222,
                  32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 1'b1, 1'b1};
      vecs[2] = '{32'hBFC0_0000, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h3C1D_BFC0,
                  32'hBFC0_0000, 1'b1, 1'b0, 32'h0, 4'hF, 1'b0, 1'b1};
      vecs[3] = '{32'h0, 1'b0, 32'h0000_1000, 1'b0, 1'b1, 32'h1234_5678, 4'h3, 32'h4444_4444,
                  32'h0000_1000, 1'b0, 1'b1, 32'h1234_5678, 4'h3, 1'b1, 1'b0};
      vecs[4] = '{32'h0, 1'b0, 32'h0000_2004, 1'b1, 1'b0, 32'h0, 4'hC, 32'h55AA_00FF,
                  32'h0000_2004, 1'b1, 1'b0, 32'h0, 4'hC, 1'b1, 1'b0};
      vecs[5] = '{32'h0000_0040, 1'b1, 32'h0000_9999, 1'b0, 1'b0, 32'h0000_0077, 4'h6, 32'h6666_6666,
                  32'h0000_0040, 1'b1, 1'b0, 32'h0, 4'hF, 1'b0, 1'b1};

      // Reset state: strobes forced low and both requesters stalled.
      clear_inputs();
      reset     = 1'b1;
      i_read    = 1'b1;
      i_address = 32'h0000_0040;
      #1;
      chk("rst_read", {31'h0, read}, 32'h0);
      chk("rst_iwait", {31'h0, i_waitrequest}, 32'h1);
      chk("rst_dwait", {31'h0, d_waitrequest}, 32'h1);
      tick();
      chk("rst_bus_error", {31'h0, bus_error}, 32'h0);
      reset = 1'b0;
      clear_inputs();
      tick();

      // Table-driven single-cycle vectors.
      for (int k = 0; k < 6; k++) begin
         i_address    = vecs[k].ia;
         i_read       = vecs[k].ir;
         d_address    = vecs[k].da;
         d_read       = vecs[k].dr;
         d_write      = vecs[k].dw;
         d_writedata  = vecs[k].dwd;
         d_byteenable = vecs[k].dbe;
         readdata     = vecs[k].rd;
         waitrequest  = 1'b0;
         #1;
         chk($sformatf("v%0d_addr", k), address, vecs[k].e_addr);
         chk($sformatf("v%0d_read", k), {31'h0, read}, {31'h0, vecs[k].e_rd});
         chk($sformatf("v%0d_write", k), {31'h0, write}, {31'h0, vecs[k].e_wr});
         chk($sformatf("v%0d_wdata", k), writedata, vecs[k].e_wd);
         chk($sformatf("v%0d_be", k), {28'h0, byteenable}, {28'h0, vecs[k].e_be});
         chk($sformatf("v%0d_iwait", k), {31'h0, i_waitrequest}, {31'h0, vecs[k].e_iw});
         chk($sformatf("v%0d_dwait", k), {31'h0, d_waitrequest}, {31'h0, vecs[k].e_dw});
         chk($sformatf("v%0d_irdata", k), i_readdata, vecs[k].rd);
         chk($sformatf("v%0d_drdata", k), d_readdata, vecs[k].rd);
         tick();
      end

      // Contention: fetch vs store, both complete without stall.
      apply_reset();
      i_read       = 1'b1;
      i_address    = 32'h0000_0040;
      d_write      = 1'b1;
      d_address    = 32'h0000_1000;
      d_writedata  = 32'h1234_5678;
      d_byteenable = 4'h3;
      #1;
      chk("ct1_addr", address, RR_BUILD ? 32'h0000_0040 : 32'h0000_1000);
      chk("ct1_iwait", {31'h0, i_waitrequest}, RR_BUILD ? 32'h0 : 32'h1);
      chk("ct1_dwait", {31'h0, d_waitrequest}, RR_BUILD ? 32'h1 : 32'h0);
      chk("ct1_write", {31'h0, write}, RR_BUILD ? 32'h0 : 32'h1);
      tick();
      // The served requester withdraws; the loser is served next.
      i_read  = RR_BUILD ? 1'b0 : 1'b1;
      d_write = RR_BUILD ? 1'b1 : 1'b0;
      #1;
      chk("ct2_addr", address, RR_BUILD ? 32'h0000_1000 : 32'h0000_0040);
      chk("ct2_iwait", {31'h0, i_waitrequest}, RR_BUILD ? 32'h1 : 32'h0);
      chk("ct2_dwait", {31'h0, d_waitrequest}, RR_BUILD ? 32'h0 : 32'h1);
      chk("ct2_be", {28'h0, byteenable}, RR_BUILD ? 32'h3 : 32'hF);
      tick();
      clear_inputs();
      tick();

      // Data read stalled 3 cycles; fetch arrives in cycle 2 and waits.
      apply_reset();
      d_read       = 1'b1;
      d_address    = 32'h0000_2000;
      d_byteenable = 4'hF;
      for (int c = 1; c <= 4; c++) begin
         waitrequest = (c < 4) ? 1'b1 : 1'b0;
         readdata    = 32'hCAFE_0001;
         if (c == 2) begin
            i_read    = 1'b1;
            i_address = 32'h0000_0080;
         end
         #1;
         chk($sformatf("st%0d_addr", c), address, 32'h0000_2000);
         chk($sformatf("st%0d_dwait", c), {31'h0, d_waitrequest}, (c < 4) ? 32'h1 : 32'h0);
         chk($sformatf("st%0d_iwait", c), {31'h0, i_waitrequest}, 32'h1);
         tick();
      end
      d_read      = 1'b0;
      waitrequest = 1'b0;
      readdata    = 32'hCAFE_0002;
      #1;
      chk("st5_addr", address, 32'h0000_0080);
      chk("st5_read", {31'h0, read}, 32'h1);
      chk("st5_iwait", {31'h0, i_waitrequest}, 32'h0);
      chk("st5_bus_error", {31'h0, bus_error}, 32'h0);
      tick();
      clear_inputs();
      tick();

      // Watchdog: slave stalls forever; abort on the 4th stall cycle.
      d_read       = 1'b1;
      d_address    = 32'h0000_3000;
      d_byteenable = 4'hF;
      waitrequest  = 1'b1;
      readdata     = 32'h1357_9BDF;
      for (int c = 1; c <= 3; c++) begin
         #1;
         chk($sformatf("to%0d_dwait", c), {31'h0, d_waitrequest}, 32'h1);
         chk($sformatf("to%0d_read", c), {31'h0, read}, 32'h1);
         tick();
      end
      #1;
      chk("to4_dwait", {31'h0, d_waitrequest}, 32'h0);
      chk("to4_drdata", d_readdata, 32'hDEAD_BEEF);
      chk("to4_read", {31'h0, read}, 32'h0);
      tick();
      chk("to_bus_error_set", {31'h0, bus_error}, 32'h1);
      d_read      = 1'b0;
      i_read      = 1'b1;
      i_address   = 32'h0000_0100;
      waitrequest = 1'b0;
      readdata    = 32'h600D_F00D;
      #1;
      chk("to5_addr", address, 32'h0000_0100);
      chk("to5_iwait", {31'h0, i_waitrequest}, 32'h0);
      chk("to5_irdata", i_readdata, 32'h600D_F00D);
      tick();
      clear_inputs();
      tick();
      chk("to_bus_error_sticky", {31'h0, bus_error}, 32'h1);

      // Reset during a stalled fetch, then a clean restart.
      i_read      = 1'b1;
      i_address   = 32'h0000_0200;
      waitrequest = 1'b1;
      tick();
      tick();
      reset = 1'b1;
      #1;
      chk("rs_read_in_reset", {31'h0, read}, 32'h0);
      chk("rs_iwait_in_reset", {31'h0, i_waitrequest}, 32'h1);
      tick();
      chk("rs_bus_error_clr", {31'h0, bus_error}, 32'h0);
      chk("rs_read_after", {31'h0, read}, 32'h0);
      reset       = 1'b0;
      waitrequest = 1'b0;
      readdata    = 32'h0BAD_CAFE;
      #1;
      chk("rs_restart_addr", address, 32'h0000_0200);
      chk("rs_restart_read", {31'h0, read}, 32'h1);
      chk("rs_restart_iwait", {31'h0, i_waitrequest}, 32'h0);
      tick();

      // Five back-to-back contended transfers.
      apply_reset();
      i_read    = 1'b1;
      i_address = 32'h0000_0400;
      d_read    = 1'b1;
      d_address = 32'h0000_0800;
      d_byteenable = 4'hF;
      for (int c = 0; c < 5; c++) begin
         #1;
         chk($sformatf("alt%0d_addr", c), address,
             (RR_BUILD && (c % 2 == 0)) ? 32'h0000_0400 : 32'h0000_0800);
         chk($sformatf("alt%0d_iwait", c), {31'h0, i_waitrequest},
             (RR_BUILD && (c % 2 == 0)) ? 32'h0 : 32'h1);
         tick();
      end
      clear_inputs();
      tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
